// File: rtl/i2c_passthru_pkg.sv
// ---------------------------------------------------------------------------
// i2c_passthru_pkg
// Shared definitions for the multi-channel I2C pass-through bit transmitter.
//   state_e    : bit-level FSM state encoding
//   max2       : larger of two integers
//   cnt_width  : bits needed to hold counts 0..max_count
// ---------------------------------------------------------------------------
package i2c_passthru_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RISE  = 3'd2,
    ST_HIGH  = 3'd3,
    ST_MID   = 3'd4,
    ST_FALL  = 3'd5
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Smallest w with 2**w > max_count, i.e. ceil(log2(max_count + 1)).
  function automatic int cnt_width(input int max_count);
    int w;
    w = 1;
    while ((1 << w) <= max_count) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/i2c_passthru_pin_check.sv
// ---------------------------------------------------------------------------
// i2c_passthru_pin_check
// Per-channel bus observer. Purely combinational; the top registers
// everything that leaves the block.
//   i_en           : channel participates in the current transfer
//   i_drive_chk    : 1 when the master is driving SDA (compare enabled)
//   i_exp_sda      : SDA value the master intends on the wire
//   i_scl / i_sda  : synchronised pad levels
//   o_sda_mismatch : enabled, driving, and the wire disagrees with us
//   o_scl_drop     : enabled and SCL observed low
// ---------------------------------------------------------------------------
module i2c_passthru_pin_check
  import i2c_passthru_pkg::*;
(
  input  logic i_en,
  input  logic i_drive_chk,
  input  logic i_exp_sda,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_mismatch,
  output logic o_scl_drop
);

  assign o_sda_mismatch = i_en & i_drive_chk & (i_sda != i_exp_sda);
  assign o_scl_drop     = i_en & ~i_scl;

endmodule

// File: rtl/i2c_passthru_bittx_nch.sv
// ---------------------------------------------------------------------------
// i2c_passthru_bittx_nch
// Drives one I2C bit (optionally with a START/STOP edge during SCL high)
// onto N_CH downstream buses in lockstep, with clock stretching, a single
// SDA sample per bit and per-channel fault reporting.
//
// Ports
//   i_clk, rstn             : clock, synchronous active-low reset
//   i_start_tx              : request a bit transfer (honoured in IDLE only)
//   i_ch_en [N_CH]          : channel participation mask (latched at accept)
//   i_dir                   : 0 = drive i_bit, 1 = release SDA and receive
//   i_bit                   : SDA value during SCL low
//   i_mid_valid, i_mid_sda  : optional SDA change while SCL high
//   i_scl, i_sda [N_CH]     : synchronised pad inputs
//   o_scl, o_sda [N_CH]     : open-drain controls (1 = release, 0 = pull low)
//   o_busy                  : not IDLE
//   o_tx_done               : one-cycle pulse at bit completion
//   o_sda_rx                : wired-AND of enabled SDA at the sample point
//   o_violation             : one-cycle pulse on a bus fault
//   o_viol_ch [N_CH]        : per-channel fault flags, cleared at accept
// ---------------------------------------------------------------------------
module i2c_passthru_bittx_nch
  import i2c_passthru_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int F_REF_T_R   = 15,
  parameter int F_REF_T_LOW = 38,
  parameter int CNT_W       = cnt_width(max2(F_REF_T_R, F_REF_T_LOW))
) (
  input  logic            i_clk,
  input  logic            rstn,
  input  logic            i_start_tx,
  input  logic [N_CH-1:0] i_ch_en,
  input  logic            i_dir,
  input  logic            i_bit,
  input  logic            i_mid_valid,
  input  logic            i_mid_sda,
  input  logic [N_CH-1:0] i_scl,
  input  logic [N_CH-1:0] i_sda,
  output logic [N_CH-1:0] o_scl,
  output logic [N_CH-1:0] o_sda,
  output logic            o_busy,
  output logic            o_tx_done,
  output logic            o_sda_rx,
  output logic            o_violation,
  output logic [N_CH-1:0] o_viol_ch
);

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(F_REF_T_LOW - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(F_REF_T_R - 1);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(F_REF_T_R);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  ch_en_q, ch_en_d;
  logic             dir_q, dir_d;
  logic             bit_q, bit_d;
  logic             mid_valid_q, mid_valid_d;
  logic             mid_sda_q, mid_sda_d;
  logic             hold_q, hold_d;
  logic [N_CH-1:0]  scl_q, scl_d;
  logic [N_CH-1:0]  sda_q, sda_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic             sda_rx_q, sda_rx_d;
  logic             violation_q, violation_d;
  logic [N_CH-1:0]  viol_ch_q, viol_ch_d;

  logic [N_CH-1:0]  sda_mismatch;
  logic [N_CH-1:0]  scl_drop;
  logic             scl_all_high;
  logic             sda_wired_and;
  logic             data_bit;

  for (genvar g = 0; g < N_CH; g++) begin : g_pin
    i2c_passthru_pin_check u_pin_check (
      .i_en           (ch_en_q[g]),
      .i_drive_chk    (~dir_q),
      .i_exp_sda      (bit_q),
      .i_scl          (i_scl[g]),
      .i_sda          (i_sda[g]),
      .o_sda_mismatch (sda_mismatch[g]),
      .o_scl_drop     (scl_drop[g])
    );
  end

  // Disabled channels count as "high" so an empty mask never stalls RISE
  // and reads back as 1.
  assign scl_all_high  = &(i_scl | ~ch_en_q);
  assign sda_wired_and = &(i_sda | ~ch_en_q);

  // Next-state, latching and status logic.
  always_comb begin
    state_d     = state_q;
    ch_en_d     = ch_en_q;
    dir_d       = dir_q;
    bit_d       = bit_q;
    mid_valid_d = mid_valid_q;
    mid_sda_d   = mid_sda_q;
    hold_d      = hold_q;
    sda_rx_d    = sda_rx_q;
    viol_ch_d   = viol_ch_q;
    tx_done_d   = 1'b0;
    violation_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start_tx) begin
          ch_en_d     = i_ch_en;
          dir_d       = i_dir;
          bit_d       = i_bit;
          mid_valid_d = i_mid_valid;
          mid_sda_d   = i_mid_sda;
          viol_ch_d   = '0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == LOW_LAST) state_d = ST_RISE;
      end

      // Clock stretching: no timeout, a slave may hold SCL as long as it likes.
      ST_RISE: begin
        if (scl_all_high) state_d = ST_HIGH;
      end

      // An SCL drop aborts immediately; it takes priority over the sample.
      ST_HIGH: begin
        if (|scl_drop) begin
          viol_ch_d   = viol_ch_q | scl_drop;
          violation_d = 1'b1;
          hold_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          if (cnt_q == SAMPLE_AT) begin
            sda_rx_d  = sda_wired_and;
            viol_ch_d = viol_ch_q | sda_mismatch;
          end
          if (cnt_q == LOW_LAST) state_d = mid_valid_q ? ST_MID : ST_FALL;
        end
      end

      // A STOP leaves the bus fully released; a START continues into FALL.
      ST_MID: begin
        if (|scl_drop) begin
          viol_ch_d   = viol_ch_q | scl_drop;
          violation_d = 1'b1;
          hold_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_q == LOW_LAST) begin
          if (mid_sda_q) begin
            hold_d      = 1'b0;
            tx_done_d   = 1'b1;
            violation_d = |viol_ch_q;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_FALL;
          end
        end
      end

      ST_FALL: begin
        if (cnt_q == RISE_LAST) begin
          hold_d      = 1'b1;
          tx_done_d   = 1'b1;
          violation_d = |viol_ch_q;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Counter restarts on every state change and saturates otherwise, so a
    // long stretch in RISE can never wrap it.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Pad drive for the state being entered, so pads change on the same edge
  // as the state. FALL and held IDLE keep whatever SDA level is already out.
  always_comb begin
    data_bit = dir_d ? 1'b1 : bit_d;
    scl_d    = '1;
    sda_d    = '1;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_en_d[c]) begin
        case (state_d)
          ST_IDLE: begin
            if (hold_d) begin
              scl_d[c] = 1'b0;
              sda_d[c] = sda_q[c];
            end
          end
          ST_SETUP: begin
            scl_d[c] = 1'b0;
            sda_d[c] = data_bit;
          end
          ST_RISE, ST_HIGH: begin
            sda_d[c] = data_bit;
          end
          ST_MID: begin
            sda_d[c] = mid_sda_d;
          end
          ST_FALL: begin
            scl_d[c] = 1'b0;
            sda_d[c] = sda_q[c];
          end
          default: begin
            scl_d[c] = 1'b1;
            sda_d[c] = 1'b1;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ch_en_q     <= '0;
      dir_q       <= 1'b0;
      bit_q       <= 1'b0;
      mid_valid_q <= 1'b0;
      mid_sda_q   <= 1'b0;
      hold_q      <= 1'b0;
      scl_q       <= '1;
      sda_q       <= '1;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      sda_rx_q    <= 1'b0;
      violation_q <= 1'b0;
      viol_ch_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_en_q     <= ch_en_d;
      dir_q       <= dir_d;
      bit_q       <= bit_d;
      mid_valid_q <= mid_valid_d;
      mid_sda_q   <= mid_sda_d;
      hold_q      <= hold_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      sda_rx_q    <= sda_rx_d;
      violation_q <= violation_d;
      viol_ch_q   <= viol_ch_d;
    end
  end

  assign o_scl       = scl_q;
  assign o_sda       = sda_q;
  assign o_busy      = busy_q;
  assign o_tx_done   = tx_done_q;
  assign o_sda_rx    = sda_rx_q;
  assign o_violation = violation_q;
  assign o_viol_ch   = viol_ch_q;

endmodule

// File: tb/tb_i2c_passthru_bittx_nch.sv
// ---------------------------------------------------------------------------
// tb_i2c_passthru_bittx_nch
// Bench for i2c_passthru_bittx_nch with N_CH=2, T_R=3, T_LOW=5. The pads
// are modelled as wired-AND buses that the bench can pull low per channel.
// ---------------------------------------------------------------------------
module tb_i2c_passthru_bittx_nch;

  localparam int NCH  = 2;
  localparam int TR   = 3;
  localparam int TLOW = 5;
  localparam int CW   = 3;

  logic           i_clk = 1'b0;
  logic           rstn = 1'b0;
  logic           i_start_tx = 1'b0;
  logic [NCH-1:0] i_ch_en = '0;
  logic           i_dir = 1'b0;
  logic           i_bit = 1'b0;
  logic           i_mid_valid = 1'b0;
  logic           i_mid_sda = 1'b0;
  logic [NCH-1:0] force_scl = '0;
  logic [NCH-1:0] force_sda = '0;
  logic [NCH-1:0] bus_scl, bus_sda;
  logic [NCH-1:0] o_scl, o_sda, o_viol_ch;
  logic           o_busy, o_tx_done, o_sda_rx, o_violation;

  int vectors = 0;
  int miscompares = 0;

  assign bus_scl = o_scl & ~force_scl;
  assign bus_sda = o_sda & ~force_sda;

  always #5 i_clk = ~i_clk;

  i2c_passthru_bittx_nch #(
    .N_CH        (NCH),
    .F_REF_T_R   (TR),
    .F_REF_T_LOW (TLOW),
    .CNT_W       (CW)
  ) dut (
    .i_clk       (i_clk),
    .rstn        (rstn),
    .i_start_tx  (i_start_tx),
    .i_ch_en     (i_ch_en),
    .i_dir       (i_dir),
    .i_bit       (i_bit),
    .i_mid_valid (i_mid_valid),
    .i_mid_sda   (i_mid_sda),
    .i_scl       (bus_scl),
    .i_sda       (bus_sda),
    .o_scl       (o_scl),
    .o_sda       (o_sda),
    .o_busy      (o_busy),
    .o_tx_done   (o_tx_done),
    .o_sda_rx    (o_sda_rx),
    .o_violation (o_violation),
    .o_viol_ch   (o_viol_ch)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Presents a request at a negedge; returns at the negedge after accept.
  task automatic startTransfer(input logic [NCH-1:0] en, input logic dir, input logic b,
                               input logic mv, input logic ms);
    i_ch_en     = en;
    i_dir       = dir;
    i_bit       = b;
    i_mid_valid = mv;
    i_mid_sda   = ms;
    i_start_tx  = 1'b1;
    @(negedge i_clk);
    i_start_tx  = 1'b0;
  endtask

  // One complete transfer checked against a behavioural model of the bus.
  // fscl is held low until k cycles after accept; fsda is held for the bit.
  task automatic applyStimulus(input string name, input logic [NCH-1:0] en, input logic dir,
                               input logic b, input logic mv, input logic ms,
                               input logic [NCH-1:0] fscl, input int k,
                               input logic [NCH-1:0] fsda, input bit scramble);
    logic           data, exp_rx, done, wire_v;
    logic [NCH-1:0] exp_viol, exp_scl, exp_sda, exp_setup_scl, exp_setup_sda, exp_mid_sda;
    int             extra, exp_cycles, n, mid_point;

    data   = dir ? 1'b1 : b;
    exp_rx = 1'b1;
    exp_viol = '0;
    for (int c = 0; c < NCH; c++) begin
      wire_v = data & ~fsda[c];
      if (en[c]) begin
        exp_rx = exp_rx & wire_v;
        if (!dir && wire_v != b) exp_viol[c] = 1'b1;
      end
      exp_setup_scl[c] = en[c] ? 1'b0 : 1'b1;
      exp_setup_sda[c] = en[c] ? data : 1'b1;
      exp_mid_sda[c]   = en[c] ? ms : 1'b1;
      if (mv && ms) begin
        exp_scl[c] = 1'b1;
        exp_sda[c] = 1'b1;
      end else begin
        exp_scl[c] = en[c] ? 1'b0 : 1'b1;
        exp_sda[c] = en[c] ? (mv ? ms : data) : 1'b1;
      end
    end
    extra = ((fscl & en) != '0 && k > TLOW) ? k - TLOW : 0;
    exp_cycles = TLOW + 1 + TLOW + extra + (mv ? TLOW : 0) + ((mv && ms) ? 0 : TR);
    mid_point  = TLOW + 1 + TLOW + extra + 1;

    force_scl = fscl;
    force_sda = fsda;
    startTransfer(en, dir, b, mv, ms);
    n = 0;
    if (k == 0) force_scl = '0;
    checkOutput({name, "_busy_at_accept"}, 32'(o_busy), 32'd1);
    checkOutput({name, "_viol_ch_cleared"}, 32'(o_viol_ch), 32'd0);

    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge i_clk);
      n++;
      if (n == 2) begin
        checkOutput({name, "_setup_scl"}, 32'(o_scl), 32'(exp_setup_scl));
        checkOutput({name, "_setup_sda"}, 32'(o_sda), 32'(exp_setup_sda));
      end
      if (mv && n == mid_point) checkOutput({name, "_mid_sda"}, 32'(o_sda), 32'(exp_mid_sda));
      if (o_tx_done) begin
        done = 1'b1;
      end else if (scramble) begin
        i_ch_en     = NCH'($urandom_range(0, 3));
        i_dir       = 1'($urandom_range(0, 1));
        i_bit       = 1'($urandom_range(0, 1));
        i_mid_valid = 1'($urandom_range(0, 1));
        i_mid_sda   = 1'($urandom_range(0, 1));
        i_start_tx  = 1'($urandom_range(0, 1));
      end
      if (n == k) force_scl = '0;
    end
    i_start_tx = 1'b0;

    checkOutput({name, "_done_seen"}, 32'(done), 32'd1);
    checkOutput({name, "_done_cycle"}, 32'(n), 32'(exp_cycles));
    checkOutput({name, "_sda_rx"}, 32'(o_sda_rx), 32'(exp_rx));
    checkOutput({name, "_viol_ch"}, 32'(o_viol_ch), 32'(exp_viol));
    checkOutput({name, "_violation"}, 32'(o_violation), 32'(exp_viol != '0));
    checkOutput({name, "_busy_end"}, 32'(o_busy), 32'd0);
    checkOutput({name, "_scl_end"}, 32'(o_scl), 32'(exp_scl));
    checkOutput({name, "_sda_end"}, 32'(o_sda), 32'(exp_sda));
    force_scl = '0;
    force_sda = '0;
    @(negedge i_clk);
    checkOutput({name, "_done_pulse_len"}, 32'(o_tx_done), 32'd0);
    checkOutput({name, "_viol_ch_held"}, 32'(o_viol_ch), 32'(exp_viol));
  endtask

  initial begin
    int seen;

    // Reset state
    rstn = 1'b0;
    waitCycles(3);
    checkOutput("rst_scl", 32'(o_scl), 32'h3);
    checkOutput("rst_sda", 32'(o_sda), 32'h3);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_tx_done), 32'd0);
    checkOutput("rst_violation", 32'(o_violation), 32'd0);
    checkOutput("rst_sda_rx", 32'(o_sda_rx), 32'd0);
    checkOutput("rst_viol_ch", 32'(o_viol_ch), 32'd0);
    rstn = 1'b1;
    waitCycles(2);

    // Plain write of 0 on both channels, bus ends held
    applyStimulus("basic", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 2'b00, 1'b0);
    // Write 1 with channel 1 SDA stuck low
    applyStimulus("arb_loss", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 0, 2'b10, 1'b0);
    // Channel 0 stretches SCL for 20 cycles in RISE
    applyStimulus("stretch", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 25, 2'b00, 1'b0);
    // STOP after a 0 bit
    applyStimulus("stop", 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 0, 2'b00, 1'b0);
    // Read with channel 0 pulling SDA low
    applyStimulus("read", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0, 2'b01, 1'b0);
    // Empty channel mask
    applyStimulus("no_ch", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 2'b00, 1'b0);
    // Repeated START edge on a single channel
    applyStimulus("rstart", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 0, 2'b00, 1'b0);

    // Reset mid-HIGH: released on the next edge, nothing reported
    startTransfer(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(8);
    rstn = 1'b0;
    waitCycles(1);
    checkOutput("rstmid_scl", 32'(o_scl), 32'h3);
    checkOutput("rstmid_sda", 32'(o_sda), 32'h3);
    checkOutput("rstmid_busy", 32'(o_busy), 32'd0);
    checkOutput("rstmid_violation", 32'(o_violation), 32'd0);
    rstn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_tx_done) seen++;
    end
    checkOutput("rstmid_no_done", 32'(seen), 32'd0);

    // Channel 1 SCL pulled low mid-HIGH: abort with violation
    startTransfer(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(7);
    force_scl = 2'b10;
    waitCycles(1);
    checkOutput("drop_violation", 32'(o_violation), 32'd1);
    checkOutput("drop_viol_ch", 32'(o_viol_ch), 32'h2);
    checkOutput("drop_done", 32'(o_tx_done), 32'd0);
    checkOutput("drop_scl", 32'(o_scl), 32'h3);
    checkOutput("drop_sda", 32'(o_sda), 32'h3);
    checkOutput("drop_busy", 32'(o_busy), 32'd0);
    force_scl = '0;
    seen = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_tx_done || o_violation) seen++;
    end
    checkOutput("drop_quiet_after", 32'(seen), 32'd0);
    checkOutput("drop_viol_ch_held", 32'(o_viol_ch), 32'h2);

    // Randomised transfers with inputs churning mid-transfer
    for (int t = 0; t < 30; t++) begin
      applyStimulus($sformatf("rnd%0d", t),
                    NCH'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), NCH'($urandom_range(0, 3)),
                    $urandom_range(0, 14), NCH'($urandom_range(0, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
